// File: rtl/flex_pts_serializer_pkg.sv
//------------------------------------------------------------------------------
// flex_pts_pkg : shared types and length helper for flex_pts_serializer
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package flex_pts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_t;

  // A length of zero or beyond the register width means "send the full word".
  function automatic int clamp_len(input int len, input int num_bits);
    if (len == 0 || len > num_bits) return num_bits;
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flex_pts_serializer.sv
//------------------------------------------------------------------------------
// flex_pts_serializer : parallel-to-serial transmitter, per-word length,
//                       one-entry hold buffer, strobe-paced shifting
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flex_pts_serializer
  import flex_pts_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1,
  parameter bit IDLE_BIT  = 1'b1,
  localparam int CNT_W    = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] parallel_in,
  input  logic [CNT_W-1:0]    bit_len,
  output logic                serial_out,
  output logic                busy,
  output logic                word_done
);

  localparam logic [NUM_BITS-1:0] IDLE_WORD = {NUM_BITS{IDLE_BIT}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  pts_state_t          state, state_nxt;
  logic [NUM_BITS-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_BITS-1:0] hold_data, hold_data_nxt;
  logic [CNT_W-1:0]    hold_len, hold_len_nxt;
  logic                hold_valid, hold_valid_nxt;
  logic                word_done_nxt;
  logic                accept;
  logic [CNT_W-1:0]    in_len;

  // MSB-first words are left-justified so bit len-1 sits at the output end.
  function automatic logic [NUM_BITS-1:0] align(input logic [NUM_BITS-1:0] d,
                                                input logic [CNT_W-1:0]    len);
    if (SHIFT_MSB) return d << (NUM_BITS - int'(len));
    return d;
  endfunction

  function automatic logic [NUM_BITS-1:0] shift_one(input logic [NUM_BITS-1:0] d);
    logic [NUM_BITS-1:0] r;
    if (SHIFT_MSB) begin
      r    = d << 1;
      r[0] = IDLE_BIT;
    end else begin
      r               = d >> 1;
      r[NUM_BITS-1]   = IDLE_BIT;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      sr         <= IDLE_WORD;
      cnt        <= '0;
      hold_data  <= '0;
      hold_len   <= '0;
      hold_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      hold_data  <= hold_data_nxt;
      hold_len   <= hold_len_nxt;
      hold_valid <= hold_valid_nxt;
      word_done  <= word_done_nxt;
    end
  end

  always_comb begin
    accept         = in_valid && !hold_valid;
    in_len         = CNT_W'(clamp_len(int'(bit_len), NUM_BITS));
    state_nxt      = state;
    sr_nxt         = sr;
    cnt_nxt        = cnt;
    hold_data_nxt  = hold_data;
    hold_len_nxt   = hold_len;
    hold_valid_nxt = hold_valid;
    word_done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          sr_nxt    = align(parallel_in, in_len);
          cnt_nxt   = in_len;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_enable && cnt > CNT_ONE) begin
          sr_nxt  = shift_one(sr);
          cnt_nxt = cnt - CNT_ONE;
          if (accept) begin
            hold_data_nxt  = parallel_in;
            hold_len_nxt   = in_len;
            hold_valid_nxt = 1'b1;
          end
        end else if (shift_enable) begin
          // Last bit retires here; the next word starts on this same edge.
          word_done_nxt = 1'b1;
          if (hold_valid) begin
            sr_nxt         = align(hold_data, hold_len);
            cnt_nxt        = hold_len;
            hold_valid_nxt = 1'b0;
          end else if (accept) begin
            sr_nxt  = align(parallel_in, in_len);
            cnt_nxt = in_len;
          end else begin
            sr_nxt    = IDLE_WORD;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else if (accept) begin
          hold_data_nxt  = parallel_in;
          hold_len_nxt   = in_len;
          hold_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == SHIFT);
    in_ready   = !hold_valid;
    serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];
  end

endmodule

`default_nettype wire

// File: tb/tb_flex_pts_serializer.sv
//------------------------------------------------------------------------------
// tb_flex_pts_serializer : scoreboard bench driving MSB-first and LSB-first
//                          instances with identical stimulus
// Revision               : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_flex_pts_serializer;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic       in_valid;
  logic [7:0] parallel_in;
  logic [3:0] bit_len;
  logic       ready_m, ready_l;
  logic       so_m, so_l;
  logic       busy_m, busy_l;
  logic       done_m, done_l;

  int total = 0;
  int bad   = 0;
  int se_mode = 2;
  int se_cnt  = 0;

  typedef struct packed {
    bit mb;
    bit lb;
    bit last;
  } exp_t;

  exp_t q[$];
  int   words_out = 0;
  bit   exp_done  = 0;

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
    .in_valid(in_valid), .in_ready(ready_m), .parallel_in(parallel_in),
    .bit_len(bit_len), .serial_out(so_m), .busy(busy_m), .word_done(done_m)
  );

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
    .in_valid(in_valid), .in_ready(ready_l), .parallel_in(parallel_in),
    .bit_len(bit_len), .serial_out(so_l), .busy(busy_l), .word_done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Strobe generator: periodic every 4th cycle, random, or always on.
  initial begin
    shift_enable = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      se_cnt = (se_cnt + 1) % 4;
      case (se_mode)
        0:       shift_enable = (se_cnt == 0);
        1:       shift_enable = 1'($urandom_range(0, 1));
        default: shift_enable = 1'b1;
      endcase
    end
  end

  // Monitor: compares outputs against the model, then advances the model by
  // the inputs that the coming edge will see.
  always @(negedge clk) begin
    bit   eb;
    bit   er;
    exp_t e;
    int   len;
    eb = (q.size() > 0);
    er = (words_out < 2);
    chk("busy_m", 32'(busy_m), 32'(eb));
    chk("busy_l", 32'(busy_l), 32'(eb));
    chk("ready_m", 32'(ready_m), 32'(er));
    chk("ready_l", 32'(ready_l), 32'(er));
    chk("done_m", 32'(done_m), 32'(exp_done));
    chk("done_l", 32'(done_l), 32'(exp_done));
    if (eb) begin
      chk("line_m", 32'(so_m), 32'(q[0].mb));
      chk("line_l", 32'(so_l), 32'(q[0].lb));
    end else begin
      chk("idle_m", 32'(so_m), 32'd1);
      chk("idle_l", 32'(so_l), 32'd1);
    end

    if (!n_rst) begin
      q.delete();
      words_out = 0;
      exp_done  = 0;
    end else begin
      exp_done = 0;
      if (eb && shift_enable) begin
        e = q.pop_front();
        if (e.last) begin
          exp_done = 1;
          words_out--;
        end
      end
      if (in_valid && er) begin
        len = (bit_len == 0 || bit_len > 8) ? 8 : int'(bit_len);
        for (int i = 0; i < len; i++) begin
          e.mb   = parallel_in[len-1-i];
          e.lb   = parallel_in[i];
          e.last = (i == len - 1);
          q.push_back(e);
        end
        words_out++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [3:0] l);
    int n;
    n = 0;
    in_valid    = 1'b1;
    parallel_in = d;
    bit_len     = l;
    while (!ready_m && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 2000) timeout("send");
    @(posedge clk);
    #2;
    in_valid    = 1'b0;
    parallel_in = 8'($urandom);
    bit_len     = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 3000) timeout("drain");
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    n_rst       = 1'b0;
    in_valid    = 1'b1;
    parallel_in = 8'hFF;
    bit_len     = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    n_rst    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    se_mode = 0;
    send(8'hA5, 4'd0);
    drain();

    send(8'hF0, 4'd0);
    send(8'h0F, 4'd0);
    drain();

    send(8'b0000_0110, 4'd3);
    drain();
    send(8'h96, 4'd9);
    drain();

    send(8'h01, 4'd0);
    drain();

    se_mode = 2;
    send(8'h3C, 4'd0);
    send(8'hC3, 4'd5);
    send(8'h81, 4'd15);
    drain();

    // Reset while one word shifts and another waits in the hold buffer.
    se_mode = 0;
    send(8'hA5, 4'd0);
    send(8'h5A, 4'd0);
    n = 0;
    while (q.size() > 13 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) timeout("midword");
    n_rst = 1'b0;
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (12) @(posedge clk);
    #2;

    for (int w = 0; w < 200; w++) begin
      if (w % 25 == 0) se_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
      send(8'($urandom), 4'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
